// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port RAM between the instruction fetch path (read only)
// and the data path (read/write). Data requests normally win arbitration,
// but a starvation counter hands the RAM to a waiting instruction fetch
// after STARVE_MAX consecutive data grants. A watchdog completes any access
// the RAM never acknowledges, so neither requester can hang.
//
// Every access runs IDLE -> I_ACC/D_ACC -> IDLE. The RAM address, write
// data and write flag come only from registers captured at the grant edge,
// so requester activity during an access cannot disturb it.
//
// Ports
//   CLK, RST         clock (rising edge), synchronous active-high reset
//   iREN, iaddr      instruction read request and address
//   iwait, iload     instruction stall (low on completion cycle) and data
//   dREN, dWEN       data read / write request (both high = write)
//   daddr, dstore    data address and write value
//   dwait, dload     data stall (low on completion cycle) and read data
//   ramREN, ramWEN   RAM read / write strobes
//   ramaddr,ramstore RAM address and write data
//   ramload          RAM read data
//   ram_ready        RAM finished the access this cycle
//   err              one-cycle pulse when an access completes by timeout
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                STARVE_MAX  = 4,
  parameter int                TIMEOUT_CYC = 64,
  parameter logic [DATA_W-1:0] ERR_WORD    = 32'hBAD1BAD1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SC_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic                write_q, write_d;

  logic                d_req;
  logic                in_acc;
  logic                to_hit;
  logic                done;
  logic                timeout;
  logic [DATA_W-1:0]   load_val;

  assign d_req   = dREN | dWEN;
  assign in_acc  = (state_q == I_ACC) || (state_q == D_ACC);
  assign to_hit  = (to_cnt_q == TO_LAST);
  // A ram_ready arriving on the watchdog's last cycle wins: it is a normal
  // completion and no error is flagged.
  assign done    = in_acc && (ram_ready || to_hit);
  assign timeout = in_acc && !ram_ready && to_hit;

  // State and latch registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      to_cnt_q     <= '0;
      addr_q       <= '0;
      store_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      to_cnt_q     <= to_cnt_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      write_q      <= write_d;
    end
  end

  // Arbitration, grant latching, starvation and watchdog counters.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    to_cnt_d     = to_cnt_q;
    addr_d       = addr_q;
    store_d      = store_q;
    write_d      = write_q;

    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (d_req && (!iREN || (starve_cnt_q < STARVE_LIM))) begin
          state_d = D_ACC;
          addr_d  = daddr;
          store_d = dstore;
          write_d = dWEN;
          // Only count grants that actually made a fetch wait.
          if (iREN) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM
                                                        : starve_cnt_q + SC_W'(1);
          end else begin
            starve_cnt_d = '0;
          end
        end else if (iREN) begin
          state_d      = I_ACC;
          addr_d       = iaddr;
          store_d      = '0;
          write_d      = 1'b0;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end

      I_ACC, D_ACC: begin
        if (done) begin
          state_d  = IDLE;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        to_cnt_d = '0;
      end
    endcase
  end

  // Requester and RAM outputs. Reset masks everything so an access cut off
  // by reset never reports a completion or an error.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    err      = 1'b0;
    load_val = timeout ? ERR_WORD : ramload;

    if (!RST && in_acc) begin
      ramREN   = ~write_q;
      ramWEN   = write_q;
      ramaddr  = addr_q;
      ramstore = store_q;
      if (done) begin
        err = timeout;
        if (state_q == I_ACC) begin
          iwait = 1'b0;
          iload = load_val;
        end else begin
          dwait = 1'b0;
          dload = write_q ? '0 : load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (one "current access" record plus a starvation count)
// predicts every output each cycle. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          SMAX = 4;
  localparam int          TOC  = 64;
  localparam logic [31:0] ERRW = 32'hBAD1BAD1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ram_ready;
  logic          err;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TOC), .ERR_WORD(ERRW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  int n_compared = 0;
  int n_failed   = 0;

  // Reference model: the access in flight (if any) and the starvation count.
  bit          m_busy   = 1'b0;
  bit          m_is_d   = 1'b0;
  bit          m_write  = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_store  = '0;
  int          m_age    = 0;
  int          m_starve = 0;

  // Last sampled completion / error outputs, for scenario-level checks.
  logic obs_iwait, obs_dwait, obs_err;

  task automatic cmpBit(input string tag, input logic obs, input logic exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cmpWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's prediction for this cycle.
  task automatic checkOutput();
    logic        tmo;
    logic        fin;
    logic [31:0] ld;
    if (RST || !m_busy) begin
      cmpBit("idle_ramREN", ramREN, 1'b0);
      cmpBit("idle_ramWEN", ramWEN, 1'b0);
      cmpBit("idle_iwait", iwait, 1'b1);
      cmpBit("idle_dwait", dwait, 1'b1);
      cmpBit("idle_err", err, 1'b0);
      cmpWord("idle_iload", iload, 32'h0);
      cmpWord("idle_dload", dload, 32'h0);
    end else begin
      tmo = !ram_ready && (m_age == TOC - 1);
      fin = ram_ready || tmo;
      ld  = tmo ? ERRW : ramload;
      cmpBit("acc_ramREN", ramREN, !m_write);
      cmpBit("acc_ramWEN", ramWEN, m_write);
      cmpWord("acc_ramaddr", ramaddr, m_addr);
      cmpWord("acc_ramstore", ramstore, m_store);
      cmpBit("acc_err", err, tmo);
      cmpBit("acc_iwait", iwait, !(fin && !m_is_d));
      cmpBit("acc_dwait", dwait, !(fin && m_is_d));
      if (fin && !m_is_d) cmpWord("acc_iload", iload, ld);
      if (fin && m_is_d)  cmpWord("acc_dload", dload, m_write ? 32'h0 : ld);
    end
    obs_iwait = iwait;
    obs_dwait = dwait;
    obs_err   = err;
  endtask

  // Advance the model across the coming rising edge.
  task automatic updateModel();
    if (RST) begin
      m_busy   = 1'b0;
      m_age    = 0;
      m_starve = 0;
    end else if (m_busy) begin
      if (ram_ready || (m_age == TOC - 1)) begin
        m_busy = 1'b0;
        m_age  = 0;
      end else begin
        m_age++;
      end
    end else if ((dREN || dWEN) && (!iREN || m_starve < SMAX)) begin
      m_busy   = 1'b1;
      m_is_d   = 1'b1;
      m_write  = dWEN;
      m_addr   = daddr;
      m_store  = dstore;
      m_age    = 0;
      m_starve = iREN ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    end else if (iREN) begin
      m_busy   = 1'b1;
      m_is_d   = 1'b0;
      m_write  = 1'b0;
      m_addr   = iaddr;
      m_store  = 32'h0;
      m_age    = 0;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
  endtask

  // One clock cycle: drive inputs, check on the falling edge, step model.
  task automatic applyStimulus(input logic rst, input logic i_ren, input logic [31:0] i_addr,
                               input logic d_ren, input logic d_wen, input logic [31:0] d_addr,
                               input logic [31:0] d_store, input logic [31:0] r_load,
                               input logic r_ready);
    RST       = rst;
    iREN      = i_ren;
    iaddr     = i_addr;
    dREN      = d_ren;
    dWEN      = d_wen;
    daddr     = d_addr;
    dstore    = d_store;
    ramload   = r_load;
    ram_ready = r_ready;
    @(negedge CLK);
    checkOutput();
    updateModel();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    byte   order[$];
    string exp_order;
    int    err_cnt;
    int    err_at;

    RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;
    @(posedge CLK);
    #1;

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h4, 1, 1, 32'h8, 32'h9, 32'h5, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lone instruction fetch, ready on the third access cycle.
    applyStimulus(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h1111, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h2222, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 32'h8C220004, 1);
    cmpBit("ifetch_done", obs_iwait, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Data write; dstore changes after the grant and must not leak through.
    applyStimulus(0, 0, 0, 0, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h100, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h100, 32'h0, 32'h12345678, 1);
    cmpBit("dwrite_done", obs_dwait, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Both sides requesting continuously: starvation limit sets the order.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, 32'h200, 1, 0, 32'h300, 0, $urandom, 1);
      if (!obs_dwait) order.push_back("D");
      if (!obs_iwait) order.push_back("I");
    end
    exp_order = "DDDDIDDDDI";
    cmpWord("order_len", order.size(), 10);
    for (int k = 0; k < 10 && k < order.size(); k++)
      cmpWord("order", 32'(order[k]), 32'(exp_order[k]));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Unacknowledged data read completes by timeout with ERR_WORD.
    applyStimulus(0, 0, 0, 1, 0, 32'h44, 0, 0, 0);
    err_cnt = 0;
    err_at  = -1;
    for (int k = 0; k < 70; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h77777777, 0);
      if (obs_err === 1'b1) begin
        err_cnt++;
        if (err_at < 0) err_at = k;
      end
    end
    cmpWord("timeout_pulses", err_cnt, 1);
    cmpWord("timeout_cycle", err_at, TOC - 1);
    applyStimulus(0, 0, 0, 1, 0, 32'h48, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'hCAFE0001, 1);
    cmpBit("after_timeout_done", obs_dwait, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Push starvation count to its limit, then reset mid-write.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 32'h80, 1, 0, 32'h600, 0, 0, 0);
      applyStimulus(0, 1, 32'h80, 1, 0, 32'h600, 0, 32'h1, 1);
    end
    applyStimulus(0, 1, 32'h80, 0, 1, 32'h700, 32'hA5A5A5A5, 0, 0);
    applyStimulus(0, 1, 32'h80, 0, 1, 32'h700, 32'hA5A5A5A5, 0, 0);
    applyStimulus(1, 1, 32'h80, 0, 1, 32'h700, 32'hA5A5A5A5, 32'h3, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h4, 1);
    // A cleared count lets the data side win again.
    applyStimulus(0, 1, 32'h80, 1, 0, 32'h600, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h55AA55AA, 1);
    cmpBit("post_reset_dwin", obs_dwait, 1'b0);

    // dREN and dWEN together form a write.
    applyStimulus(0, 0, 0, 1, 1, 32'h900, 32'h77, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h900, 32'h77, 32'hFFFF0000, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic, including drops mid-access and occasional reset.
    for (int k = 0; k < 800; k++) begin
      applyStimulus($urandom_range(0, 59) == 0,
                    1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    $urandom, $urandom, $urandom,
                    $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences one shared single-port RAM between the instruction fetch path (read-only) and the data path (read/write).
- Sits between the datapath/cache request lines and the memory.
- Data requests have priority. A starvation counter guarantees instruction forward progress.
- A timeout watchdog completes any access the RAM never acknowledges, so the core cannot hang.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while an instruction read is pending
- TIMEOUT_CYC, 64, cycles in an access state without ram_ready before forced completion
- ERR_WORD, 32'hBAD1BAD1, load value returned on timeout

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  low for exactly the completion cycle of an instruction access
- iload  out  DATA_W  instruction read data, valid when iwait=0
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dwait  out  1  low for exactly the completion cycle of a data access
- dload  out  DATA_W  data read data, valid when dwait=0 and the access was a read
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ram_ready  in  1  RAM access complete this cycle
- err  out  1  one-cycle pulse on a timeout completion

Behaviour:
- States: IDLE, I_ACC, D_ACC. Reset sets state=IDLE, starve_cnt=0, to_cnt=0, all latched request registers=0.
- Outputs: ramREN=ramWEN=0, iwait=dwait=1, err=0, iload=dload=0 whenever in IDLE or in reset.
- IDLE arbitration, evaluated each cycle:
  - If d_req=(dREN|dWEN) and (iREN=0 or starve_cnt<STARVE_MAX): go to D_ACC.
  - Else if iREN: go to I_ACC.
  - Otherwise stay in IDLE.
- Latching on grant: at the grant edge, latch addr, store data and the write flag (write=dWEN). If dREN and dWEN are both high, the access is a write.
- RAM outputs are driven only from the latched registers, never from live inputs. Requester changes after grant have no effect on the access in flight.
- In I_ACC / D_ACC: ramREN=~write, ramWEN=write, ramaddr/ramstore from the latches. to_cnt increments each cycle.
- Normal completion (ram_ready=1):
  - Granted side's wait=0 for that cycle; its load=ramload. dload=0 on a write.
  - Next state IDLE; to_cnt cleared.
  - The other side's wait stays 1.
- Timeout completion (to_cnt==TIMEOUT_CYC-1 and ram_ready=0):
  - Complete exactly as a normal completion, except load=ERR_WORD and err=1 for that cycle.
  - If ram_ready=1 on that same cycle, it is a normal completion with no err.
- Latency: request seen in IDLE at cycle 0, grant at cycle 1. ram_ready at cycle 1 gives completion in cycle 1, so the minimum is 2 cycles from request to wait=0.
- IDLE is always visited between accesses. Back-to-back accesses therefore cost at least 2 cycles each, and the RAM strobes drop for one cycle between them.
- starve_cnt rules:
  - On a D grant with iREN=1: increment, saturating at STARVE_MAX.
  - On an I grant: clear to 0.
  - In IDLE with iREN=0: clear to 0.
  - When starve_cnt==STARVE_MAX and both requests are pending, the I side wins.
- Simultaneous iREN and d_req with starve_cnt<STARVE_MAX: the D side wins.
- A requester dropping its request mid-access does not abort the RAM operation. The completion cycle still occurs, and its wait=0 is ignored by that requester.
- RST asserted mid-access: on the next edge the state returns to IDLE and the strobes fall. No completion or err is issued for the aborted access.

Test Plan:
- Lone iREN, iaddr=0x40, ram_ready on the 3rd cycle after the grant with ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 for 3 cycles; iwait=0 for one cycle with iload=0x8C220004; dwait stays 1.
- dWEN with daddr=0x100, dstore=0xDEADBEEF; dstore changed to 0 after the grant; ram_ready after 2 cycles -> ramWEN=1, ramstore=0xDEADBEEF throughout; dwait=0 for one cycle; dload=0.
- iREN and dREN held continuously, ram_ready=1 always -> grant order D,D,D,D,I,D,D,D,D,I; each iwait=0 pulse follows 4 dwait=0 pulses.
- dREN, ram_ready held 0 -> err=1 and dwait=0 with dload=0xBAD1BAD1 exactly 64 cycles after the grant; state returns to IDLE; the next request is served normally.
- RST=1 for one edge during a D_ACC write -> next cycle ramWEN=0, dwait=1, err=0, starve_cnt=0.
- dREN and dWEN both high -> treated as a write: ramWEN=1, ramREN=0.
